// File: rtl/piso_sched.sv
// piso_sched
// Two-requester round-robin scheduler and sequencer for one shared N-bit
// parallel-in/serial-out shift register that shifts LSB first.
// A request is taken only when the sequencer is idle, or on the last serial
// bit when GAP==0. The winning word goes to the shift register through
// piso_load/piso_data. Framing strobes line up cycle-for-cycle with the
// serial bits.
//
// Ports
//   clk                    clock, rising edge
//   rst                    synchronous reset, active low
//   en                     1 = new words may be accepted
//   req0_valid/req0_data   requester 0 word offer
//   req0_ready             requester 0 word accepted this cycle
//   req1_valid/req1_data   requester 1 word offer
//   req1_ready             requester 1 word accepted this cycle
//   piso_load              load strobe to the shift register (registered)
//   piso_data              parallel word to the shift register (registered, held)
//   ser_valid              serial output carries a data bit this cycle
//   ser_first / ser_last   bit 0 / bit N-1 of the word
//   ser_src                requester that owns the current word
//   bit_idx                index of the current serial bit (0 outside SHIFT)
//   busy                   sequencer not idle
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a request; accepts immediately when en=1
// S_LOAD  | piso_load high for one cycle, serial output forced off
// S_SHIFT | N serial bits; on the last bit may accept again (GAP==0)
// S_GAP   | GAP idle cycles after the last bit, then back to idle

module piso_sched #(
    parameter int N   = 4,
    parameter int GAP = 0,
    parameter int BW  = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          req0_valid,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
    output logic          piso_load,
    output logic [N-1:0]  piso_data,
    output logic          ser_valid,
    output logic          ser_first,
    output logic          ser_last,
    output logic          ser_src,
    output logic [BW-1:0] bit_idx,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);
    localparam logic [3:0]    GAP_INIT = 4'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic          NO_GAP   = (GAP == 0);

    state_t        state;
    logic          rr_ptr;     // requester preferred when both are valid
    logic [3:0]    gap_cnt;    // down-counter, terminal count at zero
    logic          last_bit;
    logic          accept_ok;
    logic          winner;
    logic          accept;
    logic [BW-1:0] next_idx;

    always_comb begin
        last_bit  = (state == S_SHIFT) && (bit_idx == LAST_IDX);
        accept_ok = en & rst & ((state == S_IDLE) | (last_bit & NO_GAP));
        // A lone valid requester always wins; a tie goes to the pointer.
        winner     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
        req0_ready = accept_ok & req0_valid & ~winner;
        req1_ready = accept_ok & req1_valid & winner;
        accept     = req0_ready | req1_ready;
        next_idx   = bit_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rr_ptr    <= 1'b0;
            gap_cnt   <= '0;
            piso_load <= 1'b0;
            piso_data <= '0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            ser_src   <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
        end else begin
            // Strobes are registered from the next state so they line up
            // with that state's cycle.
            piso_load <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            bit_idx   <= '0;
            if (accept) begin
                piso_data <= winner ? req1_data : req0_data;
                ser_src   <= winner;
                rr_ptr    <= ~winner;
                state     <= S_LOAD;
                piso_load <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_LOAD: begin
                        state     <= S_SHIFT;
                        ser_valid <= 1'b1;
                        ser_first <= 1'b1;
                        busy      <= 1'b1;
                    end
                    S_SHIFT: begin
                        if (last_bit) begin
                            if (GAP > 0) begin
                                state   <= S_GAP;
                                gap_cnt <= GAP_INIT;
                                busy    <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx   <= next_idx;
                            ser_valid <= 1'b1;
                            ser_last  <= (next_idx == LAST_IDX);
                            busy      <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                            busy    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_sched.sv
// tb_piso_sched
// Drives two piso_sched instances (GAP=0 and GAP=2, N=4) with the same
// directed and random stimulus. Each instance is checked every cycle against
// a timeline model. The model tracks the position inside the current word
// (0 = load cycle, 1..N = serial bits, then GAP idle cycles) and the
// requester granted last.

module tb_piso_sched;
    localparam int N  = 4;
    localparam int BW = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic [N-1:0] req0_data = '0;
    logic [N-1:0] req1_data = '0;

    logic          a_r0, a_r1, a_ld, a_sv, a_sf, a_sl, a_src, a_bz;
    logic [N-1:0]  a_pd;
    logic [BW-1:0] a_bi;
    logic          b_r0, b_r1, b_ld, b_sv, b_sf, b_sl, b_src, b_bz;
    logic [N-1:0]  b_pd;
    logic [BW-1:0] b_bi;

    piso_sched #(.N(N), .GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
        .piso_load(a_ld), .piso_data(a_pd), .ser_valid(a_sv),
        .ser_first(a_sf), .ser_last(a_sl), .ser_src(a_src),
        .bit_idx(a_bi), .busy(a_bz)
    );

    piso_sched #(.N(N), .GAP(2)) dut_g2 (
        .clk(clk), .rst(rst), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
        .piso_load(b_ld), .piso_data(b_pd), .ser_valid(b_sv),
        .ser_first(b_sf), .ser_last(b_sl), .ser_src(b_src),
        .bit_idx(b_bi), .busy(b_bz)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state, one entry per instance.
    int           gm    [2] = '{0, 2};
    int           pos   [2];   // -1 idle, 0 load, 1..N bits, N+1..N+GAP gap
    logic         lastg [2];   // requester granted last
    logic [N-1:0] md    [2];
    logic         ms    [2];
    logic         mrdy0 [2];
    logic         mrdy1 [2];
    logic         mwin  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pos[m]   = -1;
            lastg[m] = 1'b1;   // requester 0 preferred after reset
            md[m]    = '0;
            ms[m]    = 1'b0;
        end
    endtask

    task automatic model_eval(input int m);
        logic ok;
        ok = en && rst && (pos[m] == -1 || (gm[m] == 0 && pos[m] == N));
        if (req0_valid && req1_valid) mwin[m] = lastg[m] ? 1'b0 : 1'b1;
        else                          mwin[m] = req1_valid;
        mrdy0[m] = ok && req0_valid && (mwin[m] == 1'b0);
        mrdy1[m] = ok && req1_valid && (mwin[m] == 1'b1);
    endtask

    task automatic model_advance(input int m);
        if (!rst) begin
            pos[m] = -1; lastg[m] = 1'b1; md[m] = '0; ms[m] = 1'b0;
        end else if (mrdy0[m] || mrdy1[m]) begin
            pos[m]   = 0;
            md[m]    = mwin[m] ? req1_data : req0_data;
            ms[m]    = mwin[m];
            lastg[m] = mwin[m];
        end else if (pos[m] != -1) begin
            pos[m] = (pos[m] == N + gm[m]) ? -1 : pos[m] + 1;
        end
    endtask

    task automatic check_one(input int m, input logic r0, input logic r1, input logic ld,
                             input logic [N-1:0] pd, input logic sv, input logic sf,
                             input logic sl, input logic src, input logic [BW-1:0] bi,
                             input logic bz);
        string p;
        int    p_now;
        logic  in_bits;
        p       = $sformatf("gap%0d_", gm[m]);
        p_now   = pos[m];
        in_bits = (p_now >= 1) && (p_now <= N);
        model_eval(m);
        chk({p, "req0_ready"}, r0, mrdy0[m]);
        chk({p, "req1_ready"}, r1, mrdy1[m]);
        chk({p, "piso_load"},  ld, p_now == 0);
        chk({p, "piso_data"},  pd, md[m]);
        chk({p, "ser_valid"},  sv, in_bits);
        chk({p, "ser_first"},  sf, p_now == 1);
        chk({p, "ser_last"},   sl, p_now == N);
        chk({p, "ser_src"},    src, ms[m]);
        chk({p, "bit_idx"},    bi, in_bits ? p_now - 1 : 0);
        chk({p, "busy"},       bz, p_now != -1);
    endtask

    task automatic step(input logic e, input logic r, input logic v0, input logic [N-1:0] d0,
                        input logic v1, input logic [N-1:0] d1);
        @(negedge clk);
        en = e; rst = r;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        #1;
        check_one(0, a_r0, a_r1, a_ld, a_pd, a_sv, a_sf, a_sl, a_src, a_bi, a_bz);
        check_one(1, b_r0, b_r1, b_ld, b_pd, b_sv, b_sf, b_sl, b_src, b_bi, b_bz);
        model_advance(0);
        model_advance(1);
    endtask

    function automatic logic [N-1:0] rnd();
        return N'($urandom_range(0, (1 << N) - 1));
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // Reset held: outputs at reset values, no ready.
        step(1, 0, 1, rnd(), 1, rnd());
        step(1, 0, 0, '0, 0, '0);

        // Single word from requester 0.
        step(1, 1, 1, 4'b1011, 0, '0);
        repeat (8) step(1, 1, 0, rnd(), 0, rnd());

        // Both continuously valid: alternating grants.
        repeat (22) step(1, 1, 1, rnd(), 1, rnd());
        repeat (8) step(1, 1, 0, '0, 0, '0);

        // Requester 1 only, continuously valid.
        repeat (20) step(1, 1, 0, rnd(), 1, rnd());
        repeat (8) step(1, 1, 0, '0, 0, '0);

        // en dropped mid-word, then re-enabled in idle.
        repeat (3) step(1, 1, 1, rnd(), 0, '0);
        repeat (10) step(0, 1, 1, rnd(), 0, '0);
        repeat (4) step(1, 1, 1, rnd(), 0, '0);
        repeat (8) step(1, 1, 0, '0, 0, '0);

        // Reset during SHIFT bit 2 right after a requester-0 grant.
        step(1, 1, 1, rnd(), 0, '0);
        repeat (3) step(1, 1, 0, rnd(), 0, '0);
        step(1, 0, 1, rnd(), 1, rnd());
        repeat (6) step(1, 1, 1, rnd(), 1, rnd());
        repeat (8) step(1, 1, 0, '0, 0, '0);

        // Requester 1 pulses while busy and is not accepted.
        step(1, 1, 1, rnd(), 0, '0);
        step(1, 1, 0, rnd(), 0, '0);
        step(1, 1, 0, rnd(), 1, rnd());
        repeat (8) step(1, 1, 0, rnd(), 0, rnd());
        step(1, 1, 1, rnd(), 0, rnd());
        repeat (8) step(1, 1, 0, '0, 0, '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) != 0,
                 $urandom_range(0, 1) == 1, rnd(), $urandom_range(0, 1) == 1, rnd());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
